// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by an internal word-addressed RAM. Independent read and write FSMs with
// FIXED/INCR/WRAP bursts, configurable read latency, and SLVERR on illegal or out-of-range beats.
module axi_sram_slave #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       ID_W      = 4,
   parameter int unsigned       DEPTH     = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned       RD_LAT    = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   // write address
   input  logic                awvalid_i,
   output logic                awready_o,
   input  logic [ID_W-1:0]     awid_i,
   input  logic [ADDR_W-1:0]   awaddr_i,
   input  logic [7:0]          awlen_i,
   input  logic [2:0]          awsize_i,
   input  logic [1:0]          awburst_i,
   // write data
   input  logic                wvalid_i,
   output logic                wready_o,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   input  logic                wlast_i,
   // write response
   output logic                bvalid_o,
   input  logic                bready_i,
   output logic [ID_W-1:0]     bid_o,
   output logic [1:0]          bresp_o,
   // read address
   input  logic                arvalid_i,
   output logic                arready_o,
   input  logic [ID_W-1:0]     arid_i,
   input  logic [ADDR_W-1:0]   araddr_i,
   input  logic [7:0]          arlen_i,
   input  logic [2:0]          arsize_i,
   input  logic [1:0]          arburst_i,
   // read data
   output logic                rvalid_o,
   input  logic                rready_i,
   output logic [ID_W-1:0]     rid_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic [1:0]          rresp_o,
   output logic                rlast_o
);

   localparam int unsigned     StrbW     = DATA_W / 8;
   localparam int unsigned     OffW      = $clog2(StrbW);
   localparam int unsigned     IdxW      = $clog2(DEPTH);
   localparam logic [ADDR_W:0] MemBytes  = (ADDR_W + 1)'(DEPTH * StrbW);
   localparam logic [2:0]      MaxSize   = 3'(OffW);
   localparam logic [1:0]      BurstFix  = 2'b00;
   localparam logic [1:0]      BurstWrap = 2'b10;
   localparam logic [1:0]      RespOkay  = 2'b00;
   localparam logic [1:0]      RespErr   = 2'b10;
   localparam logic [2:0]      WaitInit  = 3'(RD_LAT - 2);

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [2:0]        size,
                                                   input logic [7:0]        len,
                                                   input logic [1:0]        burst);
      logic [ADDR_W-1:0] step;
      logic [ADDR_W-1:0] incr;
      logic [ADDR_W-1:0] mask;
      step = ADDR_W'(1) << size;
      incr = addr + step;
      mask = (step * ADDR_W'({1'b0, len} + 9'd1)) - ADDR_W'(1);
      case (burst)
         BurstFix:  next_addr = addr;
         BurstWrap: next_addr = (addr & ~mask) | (incr & mask);
         default:   next_addr = incr;
      endcase
   endfunction

   // Whole-burst errors: oversize beats or a WRAP length the protocol does not allow.
   function automatic logic burst_bad(input logic [2:0] size, input logic [7:0] len,
                                      input logic [1:0] burst);
      burst_bad = (size > MaxSize) ||
                  ((burst == BurstWrap) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off      = addr - BASE_ADDR;
      in_range = (addr >= BASE_ADDR) && ({1'b0, off} < MemBytes);
   endfunction

   function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off      = addr - BASE_ADDR;
      word_idx = off[OffW +: IdxW];
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   // ---------------- write channel ----------------
   w_state_e          w_state_q, w_state_d;
   logic [ID_W-1:0]   aw_id_q, aw_id_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [2:0]        w_size_q, w_size_d;
   logic [7:0]        w_len_q, w_len_d;
   logic [1:0]        w_burst_q, w_burst_d;
   logic [7:0]        w_cnt_q, w_cnt_d;
   logic              w_berr_q, w_berr_d;
   logic              w_err_q, w_err_d;
   logic              w_do_write;

   always_comb begin
      w_state_d  = w_state_q;
      aw_id_d    = aw_id_q;
      w_addr_d   = w_addr_q;
      w_size_d   = w_size_q;
      w_len_d    = w_len_q;
      w_burst_d  = w_burst_q;
      w_cnt_d    = w_cnt_q;
      w_berr_d   = w_berr_q;
      w_err_d    = w_err_q;
      w_do_write = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            if (awvalid_i) begin
               aw_id_d   = awid_i;
               w_addr_d  = awaddr_i;
               w_size_d  = awsize_i;
               w_len_d   = awlen_i;
               w_burst_d = awburst_i;
               w_cnt_d   = awlen_i;
               w_berr_d  = burst_bad(awsize_i, awlen_i, awburst_i);
               w_err_d   = burst_bad(awsize_i, awlen_i, awburst_i);
               w_state_d = WData;
            end
         end
         WData: begin
            if (wvalid_i) begin
               w_do_write = !w_berr_q && in_range(w_addr_q);
               // A misplaced wlast flags the burst but the beat is still committed.
               if (!in_range(w_addr_q) || (wlast_i != (w_cnt_q == 8'd0))) begin
                  w_err_d = 1'b1;
               end
               w_addr_d = next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
               w_cnt_d  = w_cnt_q - 8'd1;
               if (w_cnt_q == 8'd0) begin
                  w_state_d = WResp;
               end
            end
         end
         WResp: begin
            if (bready_i) begin
               w_state_d = WIdle;
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   assign awready_o = (w_state_q == WIdle);
   assign wready_o  = (w_state_q == WData);
   assign bvalid_o  = (w_state_q == WResp);
   assign bid_o     = aw_id_q;
   assign bresp_o   = w_err_q ? RespErr : RespOkay;

   always_ff @(posedge clk_i) begin
      if (w_do_write) begin
         for (int b = 0; b < int'(StrbW); b++) begin
            if (wstrb_i[b]) begin
               mem_q[word_idx(w_addr_q)][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   // ---------------- read channel ----------------
   r_state_e          r_state_q, r_state_d;
   logic [ID_W-1:0]   r_id_q, r_id_d;
   logic [ADDR_W-1:0] r_addr_q, r_addr_d;
   logic [2:0]        r_size_q, r_size_d;
   logic [7:0]        r_len_q, r_len_d;
   logic [1:0]        r_burst_q, r_burst_d;
   logic              r_berr_q, r_berr_d;
   logic [7:0]        r_beat_q, r_beat_d;
   logic [2:0]        r_wait_q, r_wait_d;
   logic              rvalid_q, rvalid_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              rlast_q, rlast_d;

   logic              idle_fetch;
   logic [ADDR_W-1:0] f_addr;
   logic [2:0]        f_size;
   logic [7:0]        f_len;
   logic [1:0]        f_burst;
   logic              f_berr;
   logic              f_err;
   logic              r_load;
   logic              r_load_last;

   // In idle the first beat is fetched straight from the AR payload (RD_LAT = 1 path).
   assign idle_fetch = (r_state_q == RIdle);
   assign f_addr     = idle_fetch ? araddr_i  : r_addr_q;
   assign f_size     = idle_fetch ? arsize_i  : r_size_q;
   assign f_len      = idle_fetch ? arlen_i   : r_len_q;
   assign f_burst    = idle_fetch ? arburst_i : r_burst_q;
   assign f_berr     = idle_fetch ? burst_bad(arsize_i, arlen_i, arburst_i) : r_berr_q;
   assign f_err      = f_berr || !in_range(f_addr);

   always_comb begin
      r_state_d   = r_state_q;
      r_id_d      = r_id_q;
      r_addr_d    = r_addr_q;
      r_size_d    = r_size_q;
      r_len_d     = r_len_q;
      r_burst_d   = r_burst_q;
      r_berr_d    = r_berr_q;
      r_beat_d    = r_beat_q;
      r_wait_d    = r_wait_q;
      rvalid_d    = rvalid_q;
      rid_d       = rid_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      rlast_d     = rlast_q;
      r_load      = 1'b0;
      r_load_last = 1'b0;
      unique case (r_state_q)
         RIdle: begin
            if (arvalid_i) begin
               r_id_d    = arid_i;
               r_size_d  = arsize_i;
               r_len_d   = arlen_i;
               r_burst_d = arburst_i;
               r_berr_d  = f_berr;
               r_beat_d  = 8'd0;
               if (RD_LAT <= 1) begin
                  r_load      = 1'b1;
                  r_load_last = (arlen_i == 8'd0);
                  rid_d       = arid_i;
                  r_state_d   = RData;
               end else begin
                  r_addr_d  = araddr_i;
                  r_wait_d  = WaitInit;
                  r_state_d = RWait;
               end
            end
         end
         RWait: begin
            if (r_wait_q == 3'd0) begin
               r_load      = 1'b1;
               r_load_last = (r_len_q == 8'd0);
               rid_d       = r_id_q;
               r_state_d   = RData;
            end else begin
               r_wait_d = r_wait_q - 3'd1;
            end
         end
         RData: begin
            if (rready_i) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  r_state_d = RIdle;
               end else begin
                  r_load      = 1'b1;
                  r_load_last = ((r_beat_q + 8'd1) == r_len_q);
                  r_beat_d    = r_beat_q + 8'd1;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
      if (r_load) begin
         rvalid_d = 1'b1;
         rdata_d  = f_err ? '0 : mem_q[word_idx(f_addr)];
         rresp_d  = f_err ? RespErr : RespOkay;
         rlast_d  = r_load_last;
         r_addr_d = next_addr(f_addr, f_size, f_len, f_burst);
      end
   end

   assign arready_o = (r_state_q == RIdle);
   assign rvalid_o  = rvalid_q;
   assign rid_o     = rid_q;
   assign rdata_o   = rdata_q;
   assign rresp_o   = rresp_q;
   assign rlast_o   = rlast_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state_q <= WIdle;
         aw_id_q   <= '0;
         w_addr_q  <= '0;
         w_size_q  <= '0;
         w_len_q   <= '0;
         w_burst_q <= '0;
         w_cnt_q   <= '0;
         w_berr_q  <= 1'b0;
         w_err_q   <= 1'b0;
         r_state_q <= RIdle;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_size_q  <= '0;
         r_len_q   <= '0;
         r_burst_q <= '0;
         r_berr_q  <= 1'b0;
         r_beat_q  <= '0;
         r_wait_q  <= '0;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         aw_id_q   <= aw_id_d;
         w_addr_q  <= w_addr_d;
         w_size_q  <= w_size_d;
         w_len_q   <= w_len_d;
         w_burst_q <= w_burst_d;
         w_cnt_q   <= w_cnt_d;
         w_berr_q  <= w_berr_d;
         w_err_q   <= w_err_d;
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_size_q  <= r_size_d;
         r_len_q   <= r_len_d;
         r_burst_q <= r_burst_d;
         r_berr_q  <= r_berr_d;
         r_beat_q  <= r_beat_d;
         r_wait_q  <= r_wait_d;
         rvalid_q  <= rvalid_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: two instances (RD_LAT 1 and 4) share the write stimulus;
// reads go to the selected instance and a monitor pops expected B/R responses from queues.
module tb_axi_sram_slave;

   localparam logic [1:0] Fix = 2'b00, Inc = 2'b01, Wrp = 2'b10;
   localparam logic [1:0] Ok = 2'b00, Err = 2'b10;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rbeat_t;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } bresp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   rmode = 0;

   logic        awvalid = 0, wvalid = 0, wlast = 0, arvalid = 0, rready = 0;
   logic        bready = 1;
   logic [3:0]  awid = 0, arid = 0, wstrb = 0;
   logic [31:0] awaddr = 0, araddr = 0, wdata = 0;
   logic [7:0]  awlen = 0, arlen = 0;
   logic [2:0]  awsize = 0, arsize = 0;
   logic [1:0]  awburst = 0, arburst = 0;

   logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a, rlast_a;
   logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b, rlast_b;
   logic [3:0]  bid_a, rid_a, bid_b, rid_b;
   logic [1:0]  bresp_a, rresp_a, bresp_b, rresp_b;
   logic [31:0] rdata_a, rdata_b;

   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [3:0]  bid, rid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   rbeat_t exp_r[$];
   bresp_t exp_b[$];

   always #5 clk = ~clk;

   axi_sram_slave #(.RD_LAT(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .awvalid_i(awvalid), .awready_o(awready_a), .awid_i(awid), .awaddr_i(awaddr),
      .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
      .wvalid_i(wvalid), .wready_o(wready_a), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
      .bvalid_o(bvalid_a), .bready_i(bready), .bid_o(bid_a), .bresp_o(bresp_a),
      .arvalid_i(arvalid && !sel), .arready_o(arready_a), .arid_i(arid), .araddr_i(araddr),
      .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
      .rvalid_o(rvalid_a), .rready_i(rready), .rid_o(rid_a), .rdata_o(rdata_a),
      .rresp_o(rresp_a), .rlast_o(rlast_a)
   );

   axi_sram_slave #(.RD_LAT(4)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n),
      .awvalid_i(awvalid), .awready_o(awready_b), .awid_i(awid), .awaddr_i(awaddr),
      .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
      .wvalid_i(wvalid), .wready_o(wready_b), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
      .bvalid_o(bvalid_b), .bready_i(bready), .bid_o(bid_b), .bresp_o(bresp_b),
      .arvalid_i(arvalid && sel), .arready_o(arready_b), .arid_i(arid), .araddr_i(araddr),
      .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
      .rvalid_o(rvalid_b), .rready_i(rready), .rid_o(rid_b), .rdata_o(rdata_b),
      .rresp_o(rresp_b), .rlast_o(rlast_b)
   );

   assign awready = sel ? awready_b : awready_a;
   assign wready  = sel ? wready_b  : wready_a;
   assign bvalid  = sel ? bvalid_b  : bvalid_a;
   assign bid     = sel ? bid_b     : bid_a;
   assign bresp   = sel ? bresp_b   : bresp_a;
   assign arready = sel ? arready_b : arready_a;
   assign rvalid  = sel ? rvalid_b  : rvalid_a;
   assign rdata   = sel ? rdata_b   : rdata_a;
   assign rresp   = sel ? rresp_b   : rresp_a;
   assign rlast   = sel ? rlast_b   : rlast_a;
   assign rid     = sel ? rid_b     : rid_a;

   // rready pattern: 0 = always high, 1 = toggle every cycle, 2 = held low
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       rready = 1'b1;
            1:       rready = ~rready;
            default: rready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every handshake; also checks R stability during stalls.
   logic        stall_q = 1'b0;
   logic [38:0] stall_v = '0;
   int          beat_no = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            tests++;
            if ({rdata, rresp, rlast, rid} !== stall_v) begin
               fails++;
               $display("FAIL r_stall_stable: got %h, want %h", {rdata, rresp, rlast, rid}, stall_v);
            end
         end
         stall_q = rvalid && !rready;
         stall_v = {rdata, rresp, rlast, rid};
         if (rvalid && rready) begin
            rbeat_t e;
            tests++;
            if (exp_r.size() == 0) begin
               fails++;
               $display("FAIL r_unexpected: got data=%h resp=%0d, want no beat", rdata, rresp);
            end else begin
               e = exp_r.pop_front();
               if ({rdata, rresp, rlast, rid} !== {e.data, e.resp, e.last, e.id}) begin
                  fails++;
                  $display("FAIL r_beat%0d: got data=%h resp=%0d last=%0b id=%0d, want data=%h resp=%0d last=%0b id=%0d",
                           beat_no, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
               end
            end
            beat_no++;
         end
         if (bvalid && bready) begin
            bresp_t e;
            tests++;
            if (exp_b.size() == 0) begin
               fails++;
               $display("FAIL b_unexpected: got id=%0d resp=%0d, want no response", bid, bresp);
            end else begin
               e = exp_b.pop_front();
               if ({bid, bresp} !== {e.id, e.resp}) begin
                  fails++;
                  $display("FAIL b_resp: got id=%0d resp=%0d, want id=%0d resp=%0d",
                           bid, bresp, e.id, e.resp);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // ch: 0 = AW, 1 = W, 2 = AR
   task automatic handshake(input int ch, input string nm);
      int n = 0;
      bit done = 0;
      while (!done) begin
         @(negedge clk);
         done = (ch == 0) ? awready : (ch == 1) ? wready : arready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 50) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no ready after %0d cycles, want ready", nm, n);
            done = 1;
         end
      end
   endtask

   task automatic aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                     input logic [2:0] size, input logic [1:0] burst);
      awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1;
      handshake(0, "aw");
      awvalid = 0;
   endtask

   task automatic w(input logic [31:0] d, input logic [3:0] strb, input logic last);
      wdata = d; wstrb = strb; wlast = last; wvalid = 1;
      handshake(1, "w");
      wvalid = 0;
   endtask

   task automatic ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                     input logic [2:0] size, input logic [1:0] burst);
      arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1;
      handshake(2, "ar");
      arvalid = 0;
   endtask

   task automatic exp_rd(input logic [31:0] d, input logic [1:0] resp, input logic last,
                         input logic [3:0] id);
      rbeat_t e;
      e.data = d; e.resp = resp; e.last = last; e.id = id;
      exp_r.push_back(e);
   endtask

   task automatic exp_wr(input logic [3:0] id, input logic [1:0] resp);
      bresp_t e;
      e.id = id; e.resp = resp;
      exp_b.push_back(e);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_r.size() != 0 || exp_b.size() != 0) && n <= 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n > 200) begin
         tests++;
         fails++;
         $display("FAIL %s_drain: got %0d R and %0d B pending, want 0", nm, exp_r.size(),
                  exp_b.size());
         exp_r.delete();
         exp_b.delete();
      end
   endtask

   task automatic wr1(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] strb, input logic [2:0] size, input logic [1:0] resp);
      exp_wr(id, resp);
      aw(id, a, 8'd0, size, Inc);
      w(d, strb, 1'b1);
      drain("wr1");
   endtask

   task automatic check_idle_outputs(input string nm);
      chk({nm, "_awready"}, 64'(awready), 64'd1);
      chk({nm, "_arready"}, 64'(arready), 64'd1);
      chk({nm, "_wready"},  64'(wready),  64'd0);
      chk({nm, "_bvalid"},  64'(bvalid),  64'd0);
      chk({nm, "_rvalid"},  64'(rvalid),  64'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got no end of test, want finish");
      $fatal(1);
   end

   initial begin
      int lat;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      chk("reset_rout", {rdata, rresp, rlast, rid, bid, bresp}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single write / read back
      wr1(4'd3, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, Ok);
      exp_rd(32'hDEAD_BEEF, Ok, 1'b1, 4'd5);
      ar(4'd5, 32'h8000_0010, 8'd0, 3'd2, Inc);
      drain("t1");

      // 2: INCR write 1..4, WRAP read starting mid-block
      exp_wr(4'd1, Ok);
      aw(4'd1, 32'h8000_0100, 8'd3, 3'd2, Inc);
      for (int i = 0; i < 4; i++) w(32'(i + 1), 4'hF, i == 3);
      drain("t2w");
      exp_rd(32'd3, Ok, 1'b0, 4'd2);
      exp_rd(32'd4, Ok, 1'b0, 4'd2);
      exp_rd(32'd1, Ok, 1'b0, 4'd2);
      exp_rd(32'd2, Ok, 1'b1, 4'd2);
      ar(4'd2, 32'h8000_0108, 8'd3, 3'd2, Wrp);
      drain("t2r");

      // 4: partial strobe
      wr1(4'd4, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF, 3'd2, Ok);
      wr1(4'd4, 32'h8000_0020, 32'hAAAA_5555, 4'h3, 3'd2, Ok);
      exp_rd(32'hFFFF_5555, Ok, 1'b1, 4'd0);
      ar(4'd0, 32'h8000_0020, 8'd0, 3'd2, Inc);
      drain("t4");

      // 5: burst running off the top of memory; writes out of range / below base
      wr1(4'd6, 32'h8000_3FFC, 32'h1234_5678, 4'hF, 3'd2, Ok);
      exp_rd(32'h1234_5678, Ok, 1'b0, 4'd7);
      exp_rd(32'h0, Err, 1'b1, 4'd7);
      ar(4'd7, 32'h8000_3FFC, 8'd1, 3'd2, Inc);
      drain("t5");
      wr1(4'd8, 32'h8000_4000, 32'h1111_1111, 4'hF, 3'd2, Err);
      exp_rd(32'h0, Err, 1'b1, 4'd8);
      ar(4'd8, 32'h7FFF_FFFC, 8'd0, 3'd2, Inc);
      drain("below_base");

      // early wlast: burst errors but both beats land
      exp_wr(4'd9, Err);
      aw(4'd9, 32'h8000_0030, 8'd1, 3'd2, Inc);
      w(32'hA1, 4'hF, 1'b1);
      w(32'hA2, 4'hF, 1'b1);
      drain("wlast_w");
      exp_rd(32'hA1, Ok, 1'b0, 4'd9);
      exp_rd(32'hA2, Ok, 1'b1, 4'd9);
      ar(4'd9, 32'h8000_0030, 8'd1, 3'd2, Inc);
      drain("wlast_r");

      // oversize beats and illegal WRAP length: every beat errs, count honoured
      exp_rd(32'h0, Err, 1'b0, 4'd10);
      exp_rd(32'h0, Err, 1'b1, 4'd10);
      ar(4'd10, 32'h8000_0100, 8'd1, 3'd3, Inc);
      drain("oversize");
      for (int i = 0; i < 3; i++) exp_rd(32'h0, Err, i == 2, 4'd11);
      ar(4'd11, 32'h8000_0100, 8'd2, 3'd2, Wrp);
      drain("wrap_len");

      // FIXED burst overwrites one word; narrow byte write lands in its lane
      exp_wr(4'd12, Ok);
      aw(4'd12, 32'h8000_0040, 8'd2, 3'd2, Fix);
      w(32'h11, 4'hF, 1'b0);
      w(32'h22, 4'hF, 1'b0);
      w(32'h33, 4'hF, 1'b1);
      drain("fixed_w");
      exp_rd(32'h33, Ok, 1'b0, 4'd12);
      exp_rd(32'h33, Ok, 1'b1, 4'd12);
      ar(4'd12, 32'h8000_0040, 8'd1, 3'd2, Fix);
      drain("fixed_r");
      wr1(4'd13, 32'h8000_0050, 32'h1122_3344, 4'hF, 3'd2, Ok);
      wr1(4'd13, 32'h8000_0051, 32'h0000_AB00, 4'h2, 3'd0, Ok);
      exp_rd(32'h1122_AB44, Ok, 1'b1, 4'd13);
      ar(4'd13, 32'h8000_0051, 8'd0, 3'd0, Inc);
      drain("narrow");

      // 3: RD_LAT = 4 instance, rready toggling, 8-beat read
      sel = 1'b1;
      exp_wr(4'd14, Ok);
      aw(4'd14, 32'h8000_0200, 8'd7, 3'd2, Inc);
      for (int i = 0; i < 8; i++) w(32'h100 + 32'(i), 4'hF, i == 7);
      drain("t3w");
      rmode = 1;
      for (int i = 0; i < 8; i++) exp_rd(32'h100 + 32'(i), Ok, i == 7, 4'd15);
      ar(4'd15, 32'h8000_0200, 8'd7, 3'd2, Inc);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rvalid && lat < 20);
      chk("t3_latency", 64'(lat), 64'd4);
      drain("t3r");
      rmode = 0;
      sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 6: reset mid-burst with the first beat stalled
      rmode = 2;
      ar(4'd1, 32'h8000_0100, 8'd3, 3'd2, Inc);
      chk("t6_rvalid_before", 64'(rvalid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rvalid_async", 64'(rvalid), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle_outputs("t6_after");
      rmode = 0;
      for (int i = 0; i < 4; i++) exp_rd(32'(i + 1), Ok, i == 3, 4'd2);
      ar(4'd2, 32'h8000_0100, 8'd3, 3'd2, Inc);
      drain("t6r");

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
